demux116_tdm: RTL and testbench
===============================

Name: demux116_tdm

Overview:
- Registered 1-to-16 time-division demultiplexer: the write-side counterpart of the 16:1 mux tree.
- Accepts a stream of WIDTH-bit beats over a valid/ready handshake and distributes them into 16 held channel registers.
- Channels are filled either round-robin (sequential mode) or by explicit 4-bit channel select (addressed mode).
- Signals when a complete 16-channel frame is held, and holds the frame until the consumer acknowledges it.

Parameters:
- WIDTH, 1, bit width of each beat and of each channel register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort/clear.
- in_valid  input  1  beat on d (and sel) is valid.
- in_ready  output  1  block can accept a beat this cycle.
- d  input  WIDTH  beat data.
- sel  input  4  target channel, used in addressed mode only.
- mode  input  1  0 = sequential (round-robin), 1 = addressed.
- out_ack  input  1  consumer has taken the held frame.
- q  output  16*WIDTH  channel registers; channel k occupies q[k*WIDTH +: WIDTH].
- q_valid  output  16  per-channel written flags.
- frame_done  output  1  one-cycle pulse when the frame completes.
- dup_err  output  1  one-cycle pulse on an addressed rewrite of an already-valid channel.

Behaviour:
Reset (rst_n low, asynchronous):
- q = 0, q_valid = 0, frame_done = 0, dup_err = 0.
- Internal pointer ptr = 0, latched mode = 0, state = FILL.
- in_ready = 1 once state is FILL.

States:
- FILL: in_ready = 1.
- HOLD: in_ready = 0.
- in_ready is decoded from state only, never from in_valid.

Accept:
- A beat is accepted when in_valid && in_ready on a rising edge.
- Written data appears on q and q_valid the cycle after the accept (latency 1).

Mode latch:
- mode is sampled on the first accept of a frame (the accept when q_valid == 0) and held until the frame ends.
- mode changes mid-frame are ignored.

Sequential mode:
- Each accept writes d to channel ptr, sets q_valid[ptr], and increments ptr (4-bit).
- sel is ignored.
- The accept at ptr = 15 completes the frame; ptr wraps to 0.

Addressed mode:
- Each accept writes d to channel sel and sets q_valid[sel].
- Rewriting a channel whose flag is already set is allowed: data is overwritten, the flag stays set, and dup_err pulses in the next cycle.
- The frame completes on the accept that makes q_valid all-ones; ptr is unused.

Frame completion:
- Cycle after the completing accept: state = HOLD, frame_done = 1 for exactly one cycle.
- In HOLD, q and q_valid are stable and in_valid is ignored.

HOLD to FILL:
- out_ack in HOLD: next cycle q_valid = 0, ptr = 0, state = FILL.
- q data is retained, not zeroed.
- An accept is possible in that same FILL cycle, giving one bubble cycle minimum between frames.
- out_ack in FILL is ignored.

clr (synchronous):
- Highest priority over accept and out_ack, in any state.
- Next cycle: q = 0, q_valid = 0, ptr = 0, state = FILL; no frame_done or dup_err pulse.
- A beat presented with clr high is discarded.

rst_n mid-frame: immediate return to the reset values, with no completion pulse.

Simultaneous events:
- In FILL, out_ack together with a completing accept: out_ack is ignored and the frame still enters HOLD.

Test Plan:
- Reset then sequential fill (WIDTH=4, mode=0, d = 0x0..0xF over 16 back-to-back beats):
  - q[k] = k for all k, q_valid = 0xFFFF.
  - frame_done pulses exactly once, 1 cycle after the 16th accept.
  - in_ready = 0 thereafter until out_ack.
- Addressed fill (mode=1) in reverse order (sel = 15..0, d = sel^0xA):
  - q[k] = k^0xA for all k; frame_done fires on the sel=0 accept +1 cycle; no dup_err.
- Addressed rewrite (sel=3 with d=0x1, then sel=3 with d=0x7, then the other 15 channels):
  - dup_err pulses once, 1 cycle after the second write; q[3] = 0x7.
  - frame_done fires after the 17th accept.
- HOLD/backpressure:
  - During HOLD, in_valid high with d=0x5 for 10 cycles: q is unchanged and there are no accepts.
  - out_ack: q_valid = 0 the next cycle, and a new beat is accepted into channel 0.
- clr mid-frame (after 7 sequential beats):
  - Next cycle q = 0, q_valid = 0, no frame_done.
  - The next beat lands in channel 0; a beat presented with clr is discarded.
- Async reset mid-frame (rst_n low between clock edges after 9 beats):
  - Outputs go to reset values without a clock edge.
  - A mode toggle mid-frame in an earlier frame has no effect (sequential order is kept).

Source files
------------

// File: rtl/demux116_tdm.sv
// demux116_tdm -- registered 1-to-16 time-division demultiplexer.
//
// Accepts WIDTH-bit beats over a valid/ready handshake and writes them into
// 16 held channel registers, either round-robin (mode=0) or by explicit
// channel select (mode=1). Once all 16 channels are written, the frame is
// held and in_ready drops until the consumer acknowledges it with out_ack.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame abort/clear (highest priority)
//   in_valid   beat on d/sel is valid
//   in_ready   block can accept a beat this cycle (FILL state)
//   d          beat data
//   sel        target channel (addressed mode only)
//   mode       0 = sequential, 1 = addressed; latched on a frame's first accept
//   out_ack    consumer has taken the held frame
//   q          channel registers, channel k at q[k*WIDTH +: WIDTH]
//   q_valid    per-channel written flags
//   frame_done one-cycle pulse after the frame-completing accept
//   dup_err    one-cycle pulse after an addressed rewrite of a valid channel
module demux116_tdm #(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      d,
    input  logic [3:0]            sel,
    input  logic                  mode,
    input  logic                  out_ack,
    output logic [16*WIDTH-1:0]   q,
    output logic [15:0]           q_valid,
    output logic                  frame_done,
    output logic                  dup_err
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ptr;
    logic        mode_lat;

    logic        accept;
    logic        eff_mode;
    logic [3:0]  chan;
    logic [15:0] qv_set;
    logic        complete;
    logic        dup;

    // The mode input only matters on the first accept of a frame (no channel
    // written yet); afterwards the latched copy governs the whole frame.
    assign eff_mode = (q_valid == 16'h0000) ? mode : mode_lat;
    assign chan     = eff_mode ? sel : ptr;
    assign accept   = in_valid && (state == FILL) && !clr;
    assign qv_set   = q_valid | (16'd1 << chan);
    assign complete = accept && (eff_mode ? (qv_set == 16'hFFFF) : (ptr == 4'd15));
    assign dup      = accept && eff_mode && q_valid[chan];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == FILL);
        if (clr) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (complete) state_nxt = HOLD;
                HOLD:    if (out_ack)  state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            q_valid    <= '0;
            ptr        <= '0;
            mode_lat   <= 1'b0;
            frame_done <= 1'b0;
            dup_err    <= 1'b0;
        end else begin
            frame_done <= complete;
            dup_err    <= dup;
            if (clr) begin
                q          <= '0;
                q_valid    <= '0;
                ptr        <= '0;
                frame_done <= 1'b0;
                dup_err    <= 1'b0;
            end else if (accept) begin
                q[chan*WIDTH +: WIDTH] <= d;
                q_valid                <= qv_set;
                mode_lat               <= eff_mode;
                if (!eff_mode) begin
                    ptr <= ptr + 4'd1;
                end
            end else if ((state == HOLD) && out_ack) begin
                // Release the frame; data stays on q for the consumer.
                q_valid <= '0;
                ptr     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_demux116_tdm.sv
module tb_demux116_tdm;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  d;
    logic [3:0]    sel;
    logic          mode;
    logic          out_ack;
    logic [16*W-1:0] q;
    logic [15:0]   q_valid;
    logic          frame_done;
    logic          dup_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux116_tdm #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready), .d(d), .sel(sel), .mode(mode), .out_ack(out_ack),
        .q(q), .q_valid(q_valid), .frame_done(frame_done), .dup_err(dup_err)
    );

    function automatic logic [W-1:0] qch(input int k);
        return q[k*W +: W];
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; in_valid = 0; d = '0; sel = '0; mode = 0; out_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        checks++;
        if (q !== '0 || q_valid !== 16'h0 || frame_done !== 1'b0 || dup_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: q=%h q_valid=%h fd=%b dup=%b, required all zero",
                     q, q_valid, frame_done, dup_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1;
        cyc();
    endtask

    task automatic test_seq_fill();
        int fd_cnt = 0;
        int fd_early = 0;
        mode = 0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1; d = W'(k); sel = 4'(15 - k);
            out_ack = (k == 15);  // ack with completing accept must be ignored
            cyc();
            if (frame_done) begin
                fd_cnt++;
                if (k != 15) fd_early++;
            end
        end
        in_valid = 0; out_ack = 0;
        checks++;
        if (fd_cnt !== 1 || fd_early !== 0) begin
            errors++;
            $display("FAIL seq_frame_done: pulses=%0d early=%0d, required 1 and 0", fd_cnt, fd_early);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (qch(k) !== W'(k)) begin
                errors++;
                $display("FAIL seq_q%0d: got %h, required %h", k, qch(k), W'(k));
            end
        end
        checks++;
        if (q_valid !== 16'hFFFF) begin
            errors++;
            $display("FAIL seq_q_valid: got %h, required ffff", q_valid);
        end
        cyc();
        checks++;
        if (in_ready !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL seq_hold_entry: in_ready=%b fd=%b, required 0 0", in_ready, frame_done);
        end
    endtask

    task automatic test_hold_backpressure();
        logic [16*W-1:0] snap;
        int bad = 0;
        snap = q;
        in_valid = 1; d = 4'h5; mode = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (q !== snap || q_valid !== 16'hFFFF || in_ready !== 1'b0 || frame_done !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable: %0d disturbed cycles, required 0", bad);
        end
        in_valid = 0; out_ack = 1;
        cyc();
        out_ack = 0;
        checks++;
        if (q_valid !== 16'h0 || in_ready !== 1'b1 || q !== snap) begin
            errors++;
            $display("FAIL hold_release: q_valid=%h in_ready=%b q=%h, required 0000 1 %h",
                     q_valid, in_ready, q, snap);
        end
        in_valid = 1; d = 4'h9;
        cyc();
        in_valid = 0;
        checks++;
        if (qch(0) !== 4'h9 || q_valid !== 16'h0001) begin
            errors++;
            $display("FAIL hold_next_beat: q0=%h q_valid=%h, required 9 0001", qch(0), q_valid);
        end
        clr = 1;
        cyc();
        clr = 0;
    endtask

    task automatic test_addr_reverse();
        int fd_cnt = 0;
        int dup_cnt = 0;
        int fd_at = -1;
        mode = 1;
        for (int s = 15; s >= 0; s--) begin
            in_valid = 1; sel = 4'(s); d = W'(s) ^ 4'hA;
            cyc();
            mode = 0;  // ignored after the first accept
            if (frame_done) begin fd_cnt++; fd_at = s; end
            if (dup_err) dup_cnt++;
        end
        in_valid = 0;
        checks++;
        if (fd_cnt !== 1 || fd_at !== 0 || dup_cnt !== 0) begin
            errors++;
            $display("FAIL addr_rev_pulses: fd=%0d at sel=%0d dup=%0d, required 1 at 0, 0",
                     fd_cnt, fd_at, dup_cnt);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (qch(k) !== (W'(k) ^ 4'hA)) begin
                errors++;
                $display("FAIL addr_rev_q%0d: got %h, required %h", k, qch(k), W'(k) ^ 4'hA);
            end
        end
        out_ack = 1;
        cyc();
        out_ack = 0;
    endtask

    task automatic test_addr_rewrite();
        int fd_cnt = 0;
        int dup_cnt = 0;
        int n = 0;
        mode = 1; in_valid = 1;
        sel = 4'd3; d = 4'h1;
        cyc(); n++;
        checks++;
        if (dup_err !== 1'b0) begin
            errors++;
            $display("FAIL rewrite_first_dup: got %b, required 0", dup_err);
        end
        sel = 4'd3; d = 4'h7;
        cyc(); n++;
        checks++;
        if (dup_err !== 1'b1) begin
            errors++;
            $display("FAIL rewrite_dup_pulse: got %b, required 1", dup_err);
        end
        for (int s = 0; s < 16; s++) begin
            if (s == 3) continue;
            sel = 4'(s); d = 4'hC;
            cyc(); n++;
            if (dup_err) dup_cnt++;
            if (frame_done) fd_cnt++;
            if (frame_done && n != 17) fd_cnt += 100;
        end
        in_valid = 0;
        checks++;
        if (dup_cnt !== 0 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL rewrite_pulses: extra dup=%0d fd=%0d, required 0 and 1 (on accept 17)",
                     dup_cnt, fd_cnt);
        end
        checks++;
        if (qch(3) !== 4'h7 || q_valid !== 16'hFFFF) begin
            errors++;
            $display("FAIL rewrite_q3: q3=%h q_valid=%h, required 7 ffff", qch(3), q_valid);
        end
        out_ack = 1;
        cyc();
        out_ack = 0;
    endtask

    task automatic test_clr();
        mode = 0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1; d = W'(k + 1);
            cyc();
        end
        clr = 1; d = 4'hE;
        cyc();
        clr = 0;
        checks++;
        if (q !== '0 || q_valid !== 16'h0 || frame_done !== 1'b0 || dup_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_state: q=%h q_valid=%h fd=%b, required zeros", q, q_valid, frame_done);
        end
        d = 4'h3;
        cyc();
        in_valid = 0;
        checks++;
        if (qch(0) !== 4'h3 || q_valid !== 16'h0001) begin
            errors++;
            $display("FAIL clr_next_beat: q0=%h q_valid=%h, required 3 0001", qch(0), q_valid);
        end
        clr = 1;
        cyc();
        clr = 0;
    endtask

    task automatic test_async_reset();
        mode = 0; sel = 4'd15;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1; d = W'(k) ^ 4'h6;
            if (k == 4) mode = 1;  // mid-frame toggle must not change order
            cyc();
        end
        in_valid = 0;
        checks++;
        if (q_valid !== 16'h01FF || qch(4) !== 4'h2 || qch(8) !== 4'hE || qch(15) !== 4'h0) begin
            errors++;
            $display("FAIL mode_toggle: q_valid=%h q4=%h q8=%h q15=%h, required 01ff 2 e 0",
                     q_valid, qch(4), qch(8), qch(15));
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (q !== '0 || q_valid !== 16'h0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: q=%h q_valid=%h fd=%b rdy=%b, required 0 0 0 1",
                     q, q_valid, frame_done, in_ready);
        end
        cyc();
        rst_n = 1;
        mode = 0; in_valid = 1; d = 4'hB;
        cyc();
        in_valid = 0;
        checks++;
        if (qch(0) !== 4'hB || q_valid !== 16'h0001) begin
            errors++;
            $display("FAIL post_reset_beat: q0=%h q_valid=%h, required b 0001", qch(0), q_valid);
        end
    endtask

    initial begin
        test_reset();
        test_seq_fill();
        test_hold_backpressure();
        test_addr_reverse();
        test_addr_rewrite();
        test_clr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
